// File: rtl/param_code_lock.sv
// Serial combination lock with a run-time reprogrammable code, auto-relock timer,
// failed-attempt counter and timed alarm lockout. Outputs are decoded from the state register.
module param_code_lock #(
   parameter int                  CODE_LEN       = 4,
   parameter logic [CODE_LEN-1:0] CODE           = 4'b1100,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  OPEN_CYCLES    = 8,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic       in_valid,
   input  logic       prog,
   output logic       openlock,
   output logic       alarm,
   output logic       prog_busy,
   output logic [3:0] fail_cnt,
   output logic [1:0] state
);
   localparam int CNT_W = $clog2(CODE_LEN + 1);
   localparam int TMAX  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TMR_W = $clog2(TMAX + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);
   localparam logic [TMR_W-1:0] OPEN_T   = TMR_W'(OPEN_CYCLES);
   localparam logic [TMR_W-1:0] LOCK_T   = TMR_W'(LOCKOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [3:0]       FAIL_MAX = 4'(MAX_FAIL);
   localparam logic [3:0]       FAIL_LIM = 4'(MAX_FAIL - 1);

   typedef enum logic [1:0] {
      S_LOCKED = 2'b00,
      S_OPEN   = 2'b01,
      S_PROG   = 2'b10,
      S_ALARM  = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [CODE_LEN-1:0] code_q, code_d;
   logic [CODE_LEN-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          fail_q, fail_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [CODE_LEN-1:0] shifted;
   logic                last_bit;

   // The incoming bit completes the word on the edge it is sampled.
   assign shifted  = {shift_q[CODE_LEN-2:0], in};
   assign last_bit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_LOCKED;
         code_q  <= CODE;
         shift_q <= '0;
         cnt_q   <= '0;
         fail_q  <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
         tmr_q   <= tmr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_LOCKED: begin
            if (in_valid) begin
               shift_d = shifted;
               if (last_bit) begin
                  cnt_d = '0;
                  if (shifted == code_q) begin
                     state_d = S_OPEN;
                     tmr_d   = OPEN_T;
                     fail_d  = '0;
                  end else if (fail_q < FAIL_LIM) begin
                     fail_d = fail_q + 4'd1;
                  end else begin
                     state_d = S_ALARM;
                     fail_d  = FAIL_MAX;
                     tmr_d   = LOCK_T;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_OPEN: begin
            // A programming request takes priority over auto-relock on the final cycle.
            if (prog) begin
               state_d = S_PROG;
               cnt_d   = '0;
               shift_d = '0;
            end else if (tmr_q == TMR_ONE) begin
               state_d = S_LOCKED;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         S_PROG: begin
            if (in_valid) begin
               shift_d = shifted;
               if (last_bit) begin
                  code_d  = shifted;
                  cnt_d   = '0;
                  state_d = S_LOCKED;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            if (tmr_q == TMR_ONE) begin
               state_d = S_LOCKED;
               tmr_d   = '0;
               fail_d  = '0;
               cnt_d   = '0;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
      endcase
   end

   assign openlock  = (state_q == S_OPEN);
   assign alarm     = (state_q == S_ALARM);
   assign prog_busy = (state_q == S_PROG);
   assign fail_cnt  = fail_q;
   assign state     = state_q;

endmodule

// File: tb/tb_param_code_lock.sv
// Bench for param_code_lock: hand-written vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_param_code_lock;
   localparam int CL = 4;
   localparam int MF = 3;
   localparam int OC = 8;
   localparam int LC = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       vld = 1'b0;
   logic       prg = 1'b0;
   logic       openlock, alarm, prog_busy;
   logic [3:0] fail_cnt;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   param_code_lock #(
      .CODE_LEN(CL), .CODE(4'b1100), .MAX_FAIL(MF),
      .OPEN_CYCLES(OC), .LOCKOUT_CYCLES(LC)
   ) dut (
      .clk(clk), .rst(rst), .in(din), .in_valid(vld), .prog(prg),
      .openlock(openlock), .alarm(alarm), .prog_busy(prog_busy),
      .fail_cnt(fail_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 locked, 1 open, 2 programming, 3 alarm.
   int         m_st, m_fail, m_left;
   logic [3:0] m_code;
   bit         m_bits[$];

   function automatic logic [3:0] q2val();
      logic [3:0] v = '0;
      foreach (m_bits[k]) v = {v[2:0], m_bits[k]};
      return v;
   endfunction

   function automatic void model_reset();
      m_st = 0; m_fail = 0; m_left = 0; m_code = 4'b1100; m_bits.delete();
   endfunction

   function automatic void model_step(bit i, bit v, bit p);
      case (m_st)
         0: if (v) begin
            m_bits.push_back(i);
            if (m_bits.size() == CL) begin
               if (q2val() == m_code) begin m_st = 1; m_left = OC; m_fail = 0; end
               else if (m_fail + 1 < MF) m_fail++;
               else begin m_st = 3; m_fail = MF; m_left = LC; end
               m_bits.delete();
            end
         end
         1: if (p) begin m_st = 2; m_bits.delete(); end
            else begin m_left--; if (m_left == 0) m_st = 0; end
         2: if (v) begin
            m_bits.push_back(i);
            if (m_bits.size() == CL) begin m_code = q2val(); m_st = 0; m_bits.delete(); end
         end
         default: begin m_left--; if (m_left == 0) begin m_st = 0; m_fail = 0; end end
      endcase
   endfunction

   function automatic logic [8:0] expv(int st, int fl);
      return {2'(st), st == 1, st == 3, st == 2, 4'(fl)};
   endfunction

   function automatic logic [8:0] outs();
      return {state, openlock, alarm, prog_busy, fail_cnt};
   endfunction

   task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(bit i, bit v, bit p, string nm);
      din = i; vld = v; prg = p;
      @(posedge clk); #1;
      model_step(i, v, p);
      chk(nm, outs(), expv(m_st, m_fail));
   endtask

   task automatic send(logic [3:0] c, string nm);
      logic [3:0] t;
      t = c;
      for (int k = 3; k >= 0; k--) step(t[k], 1'b1, 1'b0, nm);
   endtask

   task automatic idle(int n, string nm);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, nm);
   endtask

   task automatic do_reset();
      rst = 1'b0; vld = 1'b0; prg = 1'b0;
      @(posedge clk); #1;
      model_reset();
      chk("reset_state", outs(), 9'h000);
      rst = 1'b1;
   endtask

   typedef struct {
      bit i; bit v; bit p;
      int st; int fl;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit i, bit v, bit p, int st, int fl);
      vec_t r;
      r.i = i; r.v = v; r.p = p; r.st = st; r.fl = fl;
      tbl.push_back(r);
   endfunction

   initial begin
      bit pend[$];
      logic [3:0] rc;
      bit b, v, p;

      // Table: open with 1100, hold 8 cycles, wrong attempt, reopen.
      add(1,1,0,0,0); add(1,1,0,0,0); add(0,1,0,0,0); add(0,1,0,1,0);
      add(1,1,0,1,0); add(0,0,1,2,0);
      tbl.delete(tbl.size() - 1);
      for (int k = 0; k < 6; k++) add(0,0,0,1,0);
      add(0,0,0,0,0);
      add(0,0,1,0,0);
      add(1,1,0,0,0); add(0,1,0,0,0); add(1,1,0,0,0); add(0,1,0,0,1);
      add(1,1,0,0,1); add(1,1,0,0,1); add(0,1,0,0,1); add(0,1,0,1,0);
      for (int k = 0; k < 7; k++) add(0,0,0,1,0);
      add(0,0,0,0,0);

      do_reset();
      foreach (tbl[n]) begin
         din = tbl[n].i; vld = tbl[n].v; prg = tbl[n].p;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d", n), outs(), expv(tbl[n].st, tbl[n].fl));
      end

      // Three wrong attempts -> alarm; correct code during alarm is ignored.
      do_reset();
      send(4'b0000, "wrong1"); send(4'b0001, "wrong2"); send(4'b1111, "wrong3");
      chk("alarm_on", {alarm, fail_cnt}, {1'b1, 4'd3});
      send(4'b1100, "alarm_ignore");
      idle(11, "alarm_hold");
      chk("alarm_last", {alarm, openlock}, 2'b10);
      idle(1, "alarm_exit");
      chk("alarm_off", {alarm, fail_cnt, state}, 7'b0);
      send(4'b1100, "post_alarm_open");
      chk("post_alarm_open_chk", openlock, 1'b1);

      // Gaps between bits.
      do_reset();
      step(1,1,0,"gap"); step(0,0,0,"gap"); step(1,1,0,"gap"); step(0,0,0,"gap");
      step(0,0,0,"gap"); step(0,1,0,"gap"); step(0,1,0,"gap");
      chk("gap_open", openlock, 1'b1);

      // Reprogram on OPEN cycle 3.
      do_reset();
      send(4'b1100, "prog_open");
      idle(2, "prog_open_wait");
      step(0,0,1,"prog_req");
      chk("prog_busy", prog_busy, 1'b1);
      step(0,1,1,"prog_b0"); step(1,0,0,"prog_gap"); step(1,1,0,"prog_b1");
      step(1,1,0,"prog_b2");
      chk("prog_busy_mid", {prog_busy, openlock}, 2'b10);
      step(0,1,0,"prog_b3");
      chk("prog_done", {state, prog_busy}, 3'b000);
      send(4'b1100, "old_code");
      chk("old_code_fails", {openlock, fail_cnt}, 5'b0_0001);
      send(4'b0110, "new_code");
      chk("new_code_opens", openlock, 1'b1);
      do_reset();
      send(4'b1100, "code_reverts");
      chk("code_reverts_chk", openlock, 1'b1);

      // Asynchronous reset mid-attempt and mid-alarm.
      do_reset();
      send(4'b0000, "pre_async");
      step(1,1,0,"async_b0"); step(1,1,0,"async_b1");
      #2 rst = 1'b0; #1;
      chk("async_mid_attempt", outs(), 9'h000);
      model_reset(); #1 rst = 1'b1;
      send(4'b1100, "async_fresh");
      chk("async_fresh_open", openlock, 1'b1);
      do_reset();
      send(4'b0101, "a1"); send(4'b0101, "a2"); send(4'b0101, "a3");
      idle(5, "alarm_run");
      #2 rst = 1'b0; #1;
      chk("async_mid_alarm", outs(), 9'h000);
      model_reset(); #1 rst = 1'b1;
      send(4'b1100, "async_alarm_fresh");
      chk("async_alarm_open", openlock, 1'b1);

      // Randomized traffic: half the attempts use the model's current code.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (pend.size() == 0) begin
            rc = ($urandom_range(0, 1) == 1) ? m_code : 4'($urandom_range(0, 15));
            for (int k = 3; k >= 0; k--) pend.push_back(rc[k]);
         end
         v = ($urandom_range(0, 3) != 0);
         p = ($urandom_range(0, 5) == 0);
         b = v ? pend.pop_front() : 1'($urandom_range(0, 1));
         step(b, v, p, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
